// File: rtl/est_pipe_if.sv
// rtl/est_pipe_if.sv - operand-in / magnitude-out handshake bundle for est_pipe
interface est_pipe_if #(
   parameter int W = 15
);
   logic           in_valid;
   logic           in_ready;
   logic [1:0]     mode;
   logic [W-1:0]   x1;
   logic [W-1:0]   x2;
   logic           out_valid;
   logic           out_ready;
   logic [W:0]     U;
   logic [W:0]     V;
   logic           sign;
   logic           z1;
   logic           z2;

   modport master (
      output in_valid, mode, x1, x2, out_ready,
      input  in_ready, out_valid, U, V, sign, z1, z2
   );

   modport slave (
      input  in_valid, mode, x1, x2, out_ready,
      output in_ready, out_valid, U, V, sign, z1, z2
   );
endinterface

// File: rtl/est_pipe.sv
// rtl/est_pipe.sv - two-stage operand estimator: per-transaction pass/negate/signed-auto magnitudes
module est_pipe #(
   parameter int W = 15
) (
   input  logic      clk,
   input  logic      rst_n,
   est_pipe_if.slave bus
);

   logic           r_s1_valid;
   logic [1:0]     r_s1_mode;
   logic [W-1:0]   r_s1_x1;
   logic [W-1:0]   r_s1_x2;

   logic           r_s2_valid;
   logic [W:0]     r_u;
   logic [W:0]     r_v;
   logic           r_sign;
   logic           r_z1;
   logic           r_z2;

   logic           w_s2_adv;
   logic           w_in_ready;
   logic           w_accept;
   logic           w_s1_adv;
   logic [W-1:0]   w_tu;
   logic [W-1:0]   w_tv;
   logic           w_sign;

   // Mode 01 negates unconditionally; a zero operand wraps back to zero.
   function automatic logic [W-1:0] f_mag(input logic [W-1:0] x, input logic [1:0] m);
      logic [W-1:0] neg;
      neg = ~x + {{(W-1){1'b0}}, 1'b1};
      case (m)
         2'b01:   f_mag = neg;
         2'b10:   f_mag = x[W-1] ? neg : x;
         default: f_mag = x;
      endcase
   endfunction

   // Ready path only looks at valid bits so it stays two gates deep from out_ready.
   assign w_s2_adv   = ~r_s2_valid | bus.out_ready;
   assign w_in_ready = ~r_s1_valid | w_s2_adv;
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_s1_adv   = r_s1_valid & w_s2_adv;

   assign w_tu   = f_mag(r_s1_x1, r_s1_mode);
   assign w_tv   = f_mag(r_s1_x2, r_s1_mode);
   assign w_sign = (r_s1_mode == 2'b10) & (r_s1_x1[W-1] ^ r_s1_x2[W-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_mode  <= 2'b00;
         r_s1_x1    <= '0;
         r_s1_x2    <= '0;
      end else begin
         r_s1_valid <= w_accept | (r_s1_valid & ~w_s2_adv);
         if (w_accept) begin
            r_s1_mode <= bus.mode;
            r_s1_x1   <= bus.x1;
            r_s1_x2   <= bus.x2;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_u        <= '0;
         r_v        <= '0;
         r_sign     <= 1'b0;
         r_z1       <= 1'b0;
         r_z2       <= 1'b0;
      end else begin
         r_s2_valid <= w_s1_adv | (r_s2_valid & ~bus.out_ready);
         if (w_s1_adv) begin
            r_u    <= {1'b0, w_tu};
            r_v    <= {1'b0, w_tv};
            r_sign <= w_sign;
            r_z1   <= (w_tu == '0);
            r_z2   <= (w_tv == '0);
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_s2_valid;
   assign bus.U         = r_u;
   assign bus.V         = r_v;
   assign bus.sign      = r_sign;
   assign bus.z1        = r_z1;
   assign bus.z2        = r_z2;

endmodule
